// File: rtl/rtb_pkg.sv
// Shared definitions for the return-target-buffer memory: default geometry
// and the clear-sweep FSM state encoding.
package rtb_pkg;

    localparam int RTB_AW = 5;
    localparam int RTB_DW = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rtb_state_e;

endpackage

// File: rtl/rtb_clr_fsm.sv
// Clear-sweep sequencer: walks every entry once after reset or flush and
// reports busy for the duration of the walk.
module rtb_clr_fsm
    import rtb_pkg::*;
#(
    parameter int AW = RTB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    rtb_state_e    state_r;
    logic [AW-1:0] ptr_r;

    // State, sweep pointer and busy flag; busy mirrors the CLEAR state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            ptr_r   <= {AW{1'b0}};
            busy    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= {AW{1'b0}};
                        busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (flush) begin
                        ptr_r <= {AW{1'b0}};
                    end else if (ptr_r == PTR_LAST) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        ptr_r   <= ptr_r + PTR_ONE;
                    end else begin
                        ptr_r <= ptr_r + PTR_ONE;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    ptr_r   <= {AW{1'b0}};
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state_r == ST_CLEAR);
    assign clr_addr = ptr_r;

endmodule

// File: rtl/rtb_mem_p.sv
// Parametrised return-target-buffer two-port memory with per-entry valid bit,
// registered read port, optional read-during-write bypass and clear sweep.
module rtb_mem_p
    import rtb_pkg::*;
#(
    parameter int AW     = RTB_AW,
    parameter int DW     = RTB_DW,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          cs,
    input  logic          web,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    input  logic          scan_test,
    output logic [DW-1:0] rd,
    output logic          rd_vld,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [DW-1:0]    rd_r;
    logic             clr_we_s;
    logic [AW-1:0]    clr_addr_s;
    logic             wr_en_s;
    logic             collide_s;

    rtb_clr_fsm #(
        .AW(AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .busy     (busy),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Host write qualification and same-address bypass detection.
    always_comb begin
        wr_en_s   = 1'b0;
        collide_s = 1'b0;
        if (cs && !web && !clr_we_s && !rst) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        if (wr_en_s && (ra == wa) && (BYPASS != 0)) begin
            collide_s = 1'b1;
        end else begin
            collide_s = 1'b0;
        end
    end

    // Array and valid-bit update: the sweep owns the array while it runs.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[clr_addr_s]   <= {DW{1'b0}};
            valid_r[clr_addr_s] <= 1'b0;
        end else if (wr_en_s) begin
            mem_r[wa]   <= wd;
            valid_r[wa] <= 1'b1;
        end
    end

    // Read port register; a read during the sweep only drops the valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_r   <= {DW{1'b0}};
            rd_vld <= 1'b0;
        end else if (cs) begin
            if (clr_we_s) begin
                rd_vld <= 1'b0;
            end else if (collide_s) begin
                rd_r   <= wd;
                rd_vld <= 1'b1;
            end else begin
                rd_r   <= mem_r[ra];
                rd_vld <= valid_r[ra];
            end
        end
    end

    // DFT output-enable gating leaves the read register itself untouched.
    assign rd = scan_test ? {DW{1'b0}} : rd_r;

endmodule

// File: tb/tb_rtb_mem_p.sv
// Bench for rtb_mem_p: bypass and non-bypass builds share stimulus and are
// compared each cycle against an array model; a small AW=3/DW=20 build is checked directly.
module tb_rtb_mem_p;

    logic        clk = 1'b0;
    logic        rst, flush, cs, web, scan_test;
    logic [4:0]  wa, ra;
    logic [11:0] wd;
    logic [11:0] rd_a, rd_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    logic        s_cs, s_web, s_flush, s_scan;
    logic [2:0]  s_wa, s_ra;
    logic [19:0] s_wd, s_rd;
    logic        s_vld, s_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a, cnt_s, cnt_f;

    // Reference model state
    logic [11:0] m_mem [32];
    logic        m_vld [32];
    int          sweep_left = 0;
    logic [11:0] e_rd_b, e_rd_nb;
    logic        e_vld_b, e_vld_nb;

    always #5 clk = ~clk;

    rtb_mem_p #(.AW(5), .DW(12), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .cs(cs), .web(web), .wa(wa), .wd(wd),
        .ra(ra), .scan_test(scan_test), .rd(rd_a), .rd_vld(vld_a), .busy(busy_a)
    );

    rtb_mem_p #(.AW(5), .DW(12), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .cs(cs), .web(web), .wa(wa), .wd(wd),
        .ra(ra), .scan_test(scan_test), .rd(rd_b), .rd_vld(vld_b), .busy(busy_b)
    );

    rtb_mem_p #(.AW(3), .DW(20), .BYPASS(1)) u_dut_s (
        .clk(clk), .rst(rst), .flush(s_flush), .cs(s_cs), .web(s_web), .wa(s_wa), .wd(s_wd),
        .ra(s_ra), .scan_test(s_scan), .rd(s_rd), .rd_vld(s_vld), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 12'h000;
            m_vld[i] = 1'b0;
        end
    endtask

    // Behavioural model: a sweep blocks access for 32 cycles and leaves
    // everything empty, so the whole array can be cleared when it starts.
    always @(posedge clk) begin
        if (rst) begin
            m_clear();
            sweep_left = 32;
            e_rd_b = 12'h000; e_rd_nb = 12'h000;
            e_vld_b = 1'b0;   e_vld_nb = 1'b0;
        end else if (sweep_left > 0) begin
            if (cs) begin
                e_vld_b  = 1'b0;
                e_vld_nb = 1'b0;
            end
            sweep_left = flush ? 32 : sweep_left - 1;
        end else begin
            if (cs) begin
                e_rd_nb  = m_mem[ra];
                e_vld_nb = m_vld[ra];
                if (!web && ra == wa) begin
                    e_rd_b  = wd;
                    e_vld_b = 1'b1;
                end else begin
                    e_rd_b  = m_mem[ra];
                    e_vld_b = m_vld[ra];
                end
                if (!web) begin
                    m_mem[wa] = wd;
                    m_vld[wa] = 1'b1;
                end
            end
            if (flush) begin
                m_clear();
                sweep_left = 32;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("busy_a", {31'd0, busy_a}, {31'd0, sweep_left > 0});
        chk("busy_b", {31'd0, busy_b}, {31'd0, sweep_left > 0});
        chk("rd_a",   {20'd0, rd_a},   {20'd0, scan_test ? 12'h000 : e_rd_b});
        chk("rd_b",   {20'd0, rd_b},   {20'd0, scan_test ? 12'h000 : e_rd_nb});
        chk("vld_a",  {31'd0, vld_a},  {31'd0, e_vld_b});
        chk("vld_b",  {31'd0, vld_b},  {31'd0, e_vld_nb});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cs = 1'b0; web = 1'b1; scan_test = 1'b0;
        wa = 5'd0; ra = 5'd0; wd = 12'h000;
        s_cs = 1'b0; s_web = 1'b1; s_flush = 1'b0; s_scan = 1'b0;
        s_wa = 3'd0; s_ra = 3'd0; s_wd = 20'h00000;

        repeat (2) cyc();
        rst = 1'b0;

        // Sweep length after reset for both geometries
        cnt_a = 0; cnt_s = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cnt_a == 0 && !busy_a) cnt_a = i;
            if (cnt_s == 0 && !s_busy) cnt_s = i;
        end
        chk("sweep_len", cnt_a, 32);
        chk("sweep_len_small", cnt_s, 8);

        // Every entry empty after the sweep
        cs = 1'b1; web = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra = 5'(a);
            cyc();
            chk("clr_rd", {20'd0, rd_a}, 32'h0);
            chk("clr_vld", {31'd0, vld_a}, 32'h0);
        end

        // Write then read with one-cycle latency
        web = 1'b0; wa = 5'd5; wd = 12'hA5C; ra = 5'd0;
        cyc();
        web = 1'b1; ra = 5'd5;
        cyc();
        chk("wr_rd_data", {20'd0, rd_a}, 32'hA5C);
        chk("wr_rd_vld", {31'd0, vld_a}, 32'h1);
        ra = 5'd6;
        cyc();
        chk("unwritten_vld", {31'd0, vld_a}, 32'h0);

        // Same-address collision in both builds
        web = 1'b0; wa = 5'd9; wd = 12'h111; ra = 5'd0;
        cyc();
        wd = 12'h222; ra = 5'd9;
        cyc();
        chk("coll_bypass", {20'd0, rd_a}, 32'h222);
        chk("coll_nobypass", {20'd0, rd_b}, 32'h111);
        web = 1'b1;
        cyc();
        chk("after_coll_a", {20'd0, rd_a}, 32'h222);
        chk("after_coll_b", {20'd0, rd_b}, 32'h222);

        // Hold with cs low, then DFT gating
        ra = 5'd5;
        cyc();
        cs = 1'b0; ra = 5'd6;
        repeat (4) begin
            cyc();
            chk("hold", {20'd0, rd_a}, 32'hA5C);
        end
        scan_test = 1'b1;
        #1;
        chk("scan_zero", {20'd0, rd_a}, 32'h0);
        scan_test = 1'b0;
        #1;
        chk("scan_off", {20'd0, rd_a}, 32'hA5C);

        // Flush mid-sweep with a blocked write
        cs = 1'b1; web = 1'b0; wa = 5'd3; wd = 12'h3C3;
        cyc();
        cs = 1'b0; web = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (10) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cnt_f = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 1) begin
                cs = 1'b1; web = 1'b0; wa = 5'd3; wd = 12'h777; ra = 5'd3;
            end else begin
                cs = 1'b0; web = 1'b1;
            end
            cyc();
            if (cnt_f == 0 && !busy_a) cnt_f = i;
        end
        chk("flush_sweep_len", cnt_f, 32);
        cs = 1'b1; web = 1'b1; ra = 5'd3;
        cyc();
        chk("flushed_vld", {31'd0, vld_a}, 32'h0);
        chk("flushed_rd", {20'd0, rd_a}, 32'h0);
        cs = 1'b0;

        // Small build: full-width data at the last address
        s_cs = 1'b1; s_web = 1'b0; s_wa = 3'd7; s_wd = 20'hFFFFF; s_ra = 3'd0;
        cyc();
        s_web = 1'b1; s_ra = 3'd7;
        cyc();
        chk("small_rd", {12'd0, s_rd}, 32'hFFFFF);
        chk("small_vld", {31'd0, s_vld}, 32'h1);
        s_ra = 3'd0;
        cyc();
        chk("small_empty_vld", {31'd0, s_vld}, 32'h0);
        chk("small_empty_rd", {12'd0, s_rd}, 32'h0);
        s_cs = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            cs        = ($urandom_range(0, 3) != 0);
            web       = $urandom_range(0, 1) != 0;
            scan_test = ($urandom_range(0, 19) == 0);
            wa        = 5'($urandom_range(0, 31));
            wd        = 12'($urandom);
            ra        = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc();
        end
        rst = 1'b0; flush = 1'b0; cs = 1'b0; scan_test = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
